sa_col_skew_feeder: RTL and testbench
=====================================

Name: sa_col_skew_feeder

Overview:
- Column-side input stage for the systolic array.
- Widens each column's W_DATA operand to the W_OUT accumulator width, using zero or sign extension selected per beat.
- Applies the diagonal skew the array needs: column c is delayed by c*SKEW_STEP cycles relative to column 0.
- Sits between the column operand source and the top row of PEs. Global stall is supported.

Parameters:
- COL, 3, number of array columns.
- W_DATA, 8, input operand width per column.
- W_OUT, 32, output width per column; W_OUT >= W_DATA, otherwise fatal elaboration error.
- SKEW_STEP, 1, extra delay cycles per column index; 0 disables skew.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  advance enable; 0 holds every pipeline register.
- i_signed  in  1  1 = sign-extend, 0 = zero-extend; sampled with the beat.
- i_data  in  COL*W_DATA  packed column operands; column 0 in the most significant slice.
- i_dv  in  COL  per-column valid; bit c belongs to column c at bit index COL-1-c (same MSB-first ordering as data).
- o_data  out  COL*W_OUT  skewed, extended operands; column 0 in the most significant slice.
- o_dv  out  COL  per-column output valid, same ordering as i_dv.
- o_busy  out  1  OR of every valid bit held anywhere in the block.

Behaviour:
- One clock, i_clk. Reset is asynchronous and active-low on i_rst_n. All registers clear to 0 on reset, so o_data=0, o_dv=0 and o_busy=0.
- Input stage, when i_en=1:
  - Each column registers its slice, extended per i_signed.
  - Zero extension: upper W_OUT-W_DATA bits = 0.
  - Sign extension: upper bits = slice MSB.
  - When W_OUT==W_DATA, the data passes through unchanged.
- Delay line per column c: depth c*SKEW_STEP registers after the input stage, carrying {dv, data}.
- Latency for column c is 1 + c*SKEW_STEP enabled cycles from i_dv sample to o_dv. Column 0 always has latency 1.
- Stall: with i_en=0, all stages hold, outputs are stable and inputs are ignored. Latency counts enabled cycles only.
- Valid bits propagate with their data. Bubbles (dv=0) also propagate, so order within a column is preserved.
- Back-to-back beats are accepted every enabled cycle. No backpressure beyond i_en.
- Data registers update on every enabled cycle, whatever the state of dv. o_data is therefore meaningful only when the matching o_dv=1 (but see the optional feature).
- Reset mid-operation discards all in-flight beats immediately; no partial output follows.
- i_en and a new beat arriving together with old beats draining: everything shifts by one stage. There is no conflict.
- i_signed is per beat: consecutive beats may use different modes.

Optional Feature:
- Macro: SA_COL_ZERO_GATE_EN.
- Defined: each o_data column slice is forced to 0 whenever its o_dv=0, via output AND-gating on the registered valid. This prevents PE toggling on bubbles.
- Undefined: o_data shows the raw registered value, including stale or bubble data.
- Latency and o_dv are identical in both builds.

Decomposition:
- Package sa_pkg:
  - localparam default widths (W_DATA, W_OUT).
  - typedef for the extension mode (EXT_ZERO, EXT_SIGN).
  - function col_slice_hi(col, width, ncol) returning the MSB index of column col's slice.
- Sub-module sa_col_delay_line:
  - parameters DEPTH and W; ports i_clk, i_rst_n, i_en, i_d[W], o_q[W].
  - DEPTH==0 is a wire passthrough.
  - Instantiated once per column with DEPTH=c*SKEW_STEP and W=W_OUT+1.

Test Plan:
1. Reset: hold i_rst_n=0 while driving random inputs with i_en=1 → o_data=0, o_dv=3'b000, o_busy=0 throughout.
2. Zero-extend skew: i_signed=0, i_data={8'hFF,8'h80,8'h01}, i_dv=3'b111 for one cycle, i_en=1 →
   - col0 shows 32'h000000FF with dv at +1.
   - col1 shows 32'h00000080 at +2.
   - col2 shows 32'h00000001 at +3.
   - Each dv is a one-cycle pulse; o_busy is high from +1 to +3.
3. Sign-extend: same stimulus with i_signed=1 → col0 32'hFFFFFFFF, col1 32'hFFFFFF80, col2 32'h00000001, with the same timing as scenario 2.
4. Stall: inject as in scenario 2, then i_en=0 for cycles +2..+3 → outputs frozen during the stall; col1 appears at +4 and col2 at +5.
5. Reset mid-flight: inject as in scenario 2, then pulse i_rst_n low at +2 → col2 o_dv never asserts; o_busy=0 immediately.
6. Streaming with mode switching: four consecutive beats 8'h7F, 8'h80, 8'h00, 8'hFE on all columns, i_signed alternating 0/1/0/1 →
   - each column outputs 0000007F, FFFFFF80, 00000000, FFFFFFFE on four contiguous dv cycles;
   - with SA_COL_ZERO_GATE_EN defined, o_data is 0 on every cycle where dv=0.

Source files
------------

// File: rtl/sa_col_skew_feeder_pkg.sv
// sa_pkg: shared definitions for the systolic-array column skew feeder.
//   - Default operand / accumulator widths.
//   - Extension-mode encoding (matches the i_signed input bit).
//   - col_slice_hi(): MSB index of a column slice in an MSB-first packed bus.
package sa_pkg;

    localparam int W_DATA_DEF = 8;
    localparam int W_OUT_DEF  = 32;

    typedef enum logic {
        EXT_ZERO = 1'b0,
        EXT_SIGN = 1'b1
    } ext_mode_e;

    // Column 0 occupies the most significant slice of the packed bus.
    function automatic int col_slice_hi(input int col, input int width, input int ncol);
        return (ncol - col) * width - 1;
    endfunction

endpackage

// File: rtl/sa_col_delay_line.sv
// sa_col_delay_line: DEPTH-stage enabled shift register with async clear.
//   DEPTH == 0 is a plain wire from i_d to o_q.
// Ports:
//   i_clk, i_rst_n (async, active low), i_en (advance; 0 holds all stages)
//   i_d [W]  stage input
//   o_q [W]  last stage output
module sa_col_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    if (DEPTH == 0) begin : g_wire
        assign o_q = i_d;
        // Clock/reset/enable have no load in the passthrough case.
        logic unused_ctl;
        assign unused_ctl = ^{i_clk, i_rst_n, i_en};
    end else begin : g_sr
        logic [DEPTH-1:0][W-1:0] sr;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sr <= '0;
            end else if (i_en) begin
                sr[0] <= i_d;
                for (int i = 1; i < DEPTH; i++) begin
                    sr[i] <= sr[i-1];
                end
            end
        end

        assign o_q = sr[DEPTH-1];
    end

endmodule

// File: rtl/sa_col_skew_feeder.sv
// sa_col_skew_feeder: column-side input stage for the systolic array.
//   Each column's W_DATA operand is registered and widened to W_OUT
//   (zero or sign extension chosen per beat by i_signed), then delayed by
//   c*SKEW_STEP further enabled cycles so column c reaches the PEs skewed
//   against column 0. Valid travels alongside data; i_en=0 freezes everything.
// Ports:
//   i_clk, i_rst_n (async, active low), i_en (global advance / stall)
//   i_signed            1 = sign-extend, 0 = zero-extend this beat
//   i_data [COL*W_DATA] column operands, column 0 in the MSB slice
//   i_dv   [COL]        per-column valid, column c at bit COL-1-c
//   o_data [COL*W_OUT]  skewed, widened operands, column 0 in the MSB slice
//   o_dv   [COL]        per-column output valid, same ordering as i_dv
//   o_busy              any valid beat held anywhere in the block
// Build option: SA_COL_ZERO_GATE_EN forces each o_data slice to 0 while its
//   o_dv is low, so bubbles do not toggle the PE inputs.
module sa_col_skew_feeder
    import sa_pkg::*;
#(
    parameter int COL       = 3,
    parameter int W_DATA    = W_DATA_DEF,
    parameter int W_OUT     = W_OUT_DEF,
    parameter int SKEW_STEP = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_signed,
    input  logic [COL*W_DATA-1:0] i_data,
    input  logic [COL-1:0]        i_dv,
    output logic [COL*W_OUT-1:0]  o_data,
    output logic [COL-1:0]        o_dv,
    output logic                  o_busy
);

    if (W_OUT < W_DATA) begin : g_bad_width
        $fatal(1, "sa_col_skew_feeder: W_OUT (%0d) must be >= W_DATA (%0d)", W_OUT, W_DATA);
    end

    ext_mode_e mode;
    assign mode = ext_mode_e'(i_signed);

    logic [COL-1:0] col_busy;

    for (genvar c = 0; c < COL; c++) begin : g_col
        localparam int HI_IN  = col_slice_hi(c, W_DATA, COL);
        localparam int HI_OUT = col_slice_hi(c, W_OUT, COL);
        localparam int DEPTH  = c * SKEW_STEP;

        logic [W_DATA-1:0] slice;
        logic [W_OUT-1:0]  ext;
        logic [W_OUT:0]    stg;   // {dv, data} after the input stage
        logic [W_OUT:0]    q;     // {dv, data} at the column output

        assign slice = i_data[HI_IN -: W_DATA];

        if (W_OUT > W_DATA) begin : g_ext
            assign ext = {{(W_OUT-W_DATA){(mode == EXT_SIGN) & slice[W_DATA-1]}}, slice};
        end else begin : g_pass
            assign ext = slice;
        end

        // Data is captured every enabled cycle, bubble or not.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                stg <= '0;
            end else if (i_en) begin
                stg <= {i_dv[COL-1-c], ext};
            end
        end

        sa_col_delay_line #(
            .DEPTH (DEPTH),
            .W     (W_OUT + 1)
        ) u_dly (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_en    (i_en),
            .i_d     (stg),
            .o_q     (q)
        );

        // Busy for the delay stages is tracked as a count of valid beats
        // inside the line: one enters from stg and one leaves from q on
        // each enabled edge, so the count is exact without tapping stages.
        if (DEPTH > 0) begin : g_cnt
            localparam int CW = $clog2(DEPTH + 1);
            logic [CW-1:0] inflight;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    inflight <= '0;
                end else if (i_en) begin
                    inflight <= inflight + CW'(stg[W_OUT]) - CW'(q[W_OUT]);
                end
            end

            assign col_busy[c] = stg[W_OUT] | (inflight != '0);
        end else begin : g_nocnt
            assign col_busy[c] = stg[W_OUT];
        end

        assign o_dv[COL-1-c] = q[W_OUT];
`ifdef SA_COL_ZERO_GATE_EN
        assign o_data[HI_OUT -: W_OUT] = q[W_OUT-1:0] & {W_OUT{q[W_OUT]}};
`else
        assign o_data[HI_OUT -: W_OUT] = q[W_OUT-1:0];
`endif
    end

    assign o_busy = |col_busy;

endmodule

// File: tb/tb_sa_col_skew_feeder.sv
module tb_sa_col_skew_feeder;

    localparam int COL    = 3;
    localparam int W_DATA = 8;
    localparam int W_OUT  = 32;
    localparam int SKEW   = 1;

    logic                  i_clk    = 1'b0;
    logic                  i_rst_n  = 1'b0;
    logic                  i_en     = 1'b0;
    logic                  i_signed = 1'b0;
    logic [COL*W_DATA-1:0] i_data   = '0;
    logic [COL-1:0]        i_dv     = '0;
    logic [COL*W_OUT-1:0]  o_data;
    logic [COL-1:0]        o_dv;
    logic                  o_busy;

    always #5 i_clk = ~i_clk;

    sa_col_skew_feeder #(
        .COL(COL), .W_DATA(W_DATA), .W_OUT(W_OUT), .SKEW_STEP(SKEW)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (i_en),
        .i_signed (i_signed),
        .i_data   (i_data),
        .i_dv     (i_dv),
        .o_data   (o_data),
        .o_dv     (o_dv),
        .o_busy   (o_busy)
    );

    int errors = 0;
    int checks = 0;
    int ecnt   = 0;     // enabled, out-of-reset clock edges seen
    bit last_en = 1'b0; // the most recent edge advanced the pipeline

    typedef struct {
        logic [W_OUT-1:0] data;
        int               due;
    } exp_t;

    exp_t sb [COL][$];

    always @(posedge i_clk) begin
        last_en = i_rst_n && i_en;
        if (last_en) ecnt++;
    end

    function automatic logic [W_OUT-1:0] col_out(input int c);
        return o_data[(COL-c)*W_OUT-1 -: W_OUT];
    endfunction

    // Scoreboard: pop and compare every output beat (data and arrival time).
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            for (int c = 0; c < COL; c++) sb[c].delete();
        end else if (last_en) begin
            for (int c = 0; c < COL; c++) begin
                if (o_dv[COL-1-c]) begin
                    checks++;
                    if (sb[c].size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected_col%0d: got beat %h, required none", c, col_out(c));
                    end else begin
                        exp_t e;
                        e = sb[c].pop_front();
                        if (col_out(c) !== e.data || ecnt != e.due) begin
                            errors++;
                            $display("FAIL sb_col%0d: got %h at cycle %0d, required %h at cycle %0d",
                                     c, col_out(c), ecnt, e.data, e.due);
                        end
                    end
                end
`ifdef SA_COL_ZERO_GATE_EN
                else begin
                    checks++;
                    if (col_out(c) !== '0) begin
                        errors++;
                        $display("FAIL gate_col%0d: got %h on bubble, required 0", c, col_out(c));
                    end
                end
`endif
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [W_DATA-1:0] d0, input logic [W_DATA-1:0] d1,
                         input logic [W_DATA-1:0] d2, input logic [COL-1:0] dv,
                         input logic sgn, input logic en);
        logic [W_DATA-1:0] d [COL];
        d[0] = d0; d[1] = d1; d[2] = d2;
        i_data = {d0, d1, d2};
        i_dv = dv;
        i_signed = sgn;
        i_en = en;
        if (en) begin
            for (int c = 0; c < COL; c++) begin
                if (dv[COL-1-c]) begin
                    exp_t e;
                    e.data = sgn ? W_OUT'($signed(d[c])) : W_OUT'(d[c]);
                    e.due  = ecnt + 1 + c * SKEW;
                    sb[c].push_back(e);
                end
            end
        end
    endtask

    task automatic idle();
        drive(W_DATA'($urandom), W_DATA'($urandom), W_DATA'($urandom), '0, 1'($urandom), 1'b1);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_en = 1'b1;
            i_data = COL*W_DATA'($urandom);
            i_dv = COL'($urandom);
            i_signed = 1'($urandom);
            @(negedge i_clk);
            checks++;
            if (o_data !== '0 || o_dv !== '0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset: got data=%h dv=%b busy=%b, required all 0", o_data, o_dv, o_busy);
            end
            tick();
        end
        i_rst_n = 1'b1;
        idle();
    endtask

    // Shared injection for zero/sign tests: one beat on all columns.
    task automatic test_ext(input logic sgn, input logic [W_OUT-1:0] e0,
                            input logic [W_OUT-1:0] e1, input logic [W_OUT-1:0] e2);
        logic [W_OUT-1:0] ev [COL];
        ev[0] = e0; ev[1] = e1; ev[2] = e2;
        drive(8'hFF, 8'h80, 8'h01, 3'b111, sgn, 1'b1);
        for (int k = 0; k < COL; k++) begin
            tick();
            idle();
            @(negedge i_clk);
            checks++;
            if (o_dv !== COL'(1 << (COL-1-k)) || col_out(k) !== ev[k] || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL ext_s%0d_+%0d: got dv=%b col=%h busy=%b, required dv=%b col=%h busy=1",
                         sgn, k+1, o_dv, col_out(k), o_busy, COL'(1 << (COL-1-k)), ev[k]);
            end
        end
        tick();
        @(negedge i_clk);
        checks++;
        if (o_dv !== '0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL ext_s%0d_drain: got dv=%b busy=%b, required 0/0", sgn, o_dv, o_busy);
        end
        tick();
    endtask

    task automatic test_stall();
        drive(8'hFF, 8'h80, 8'h01, 3'b111, 1'b0, 1'b1);
        tick();
        idle();
        @(negedge i_clk);
        i_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            @(negedge i_clk);
            checks++;
            if (o_dv !== 3'b100 || col_out(0) !== 32'h000000FF || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d: got dv=%b col0=%h busy=%b, required 100/000000FF/1",
                         k, o_dv, col_out(0), o_busy);
            end
        end
        i_en = 1'b1;
        tick();
        @(negedge i_clk);
        checks++;
        if (o_dv !== 3'b010 || col_out(1) !== 32'h00000080) begin
            errors++;
            $display("FAIL stall_col1: got dv=%b col1=%h, required 010/00000080", o_dv, col_out(1));
        end
        tick();
        @(negedge i_clk);
        checks++;
        if (o_dv !== 3'b001 || col_out(2) !== 32'h00000001) begin
            errors++;
            $display("FAIL stall_col2: got dv=%b col2=%h, required 001/00000001", o_dv, col_out(2));
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        drive(8'hFF, 8'h80, 8'h01, 3'b111, 1'b0, 1'b1);
        tick();
        idle();
        tick();
        @(negedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_dv !== '0 || o_busy !== 1'b0 || o_data !== '0) begin
            errors++;
            $display("FAIL reset_mid_now: got dv=%b busy=%b data=%h, required all 0", o_dv, o_busy, o_data);
        end
        @(posedge i_clk);
        @(negedge i_clk);
        #1;
        i_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            checks++;
            if (o_dv !== '0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_after%0d: got dv=%b busy=%b, required 0/0", k, o_dv, o_busy);
            end
        end
        tick();
    endtask

    task automatic test_stream();
        logic [W_DATA-1:0] beats [4];
        beats[0] = 8'h7F; beats[1] = 8'h80; beats[2] = 8'h00; beats[3] = 8'hFE;
        for (int k = 0; k < 4; k++) begin
            drive(beats[k], beats[k], beats[k], 3'b111, 1'(k % 2), 1'b1);
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            idle();
            tick();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            drive(W_DATA'($urandom), W_DATA'($urandom), W_DATA'($urandom), COL'($urandom),
                  1'($urandom), ($urandom_range(0, 3) != 0));
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            idle();
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_ext(1'b0, 32'h000000FF, 32'h00000080, 32'h00000001);
        test_ext(1'b1, 32'hFFFFFFFF, 32'hFFFFFF80, 32'h00000001);
        test_stall();
        test_reset_mid();
        test_stream();
        test_random();
        @(negedge i_clk);
        for (int c = 0; c < COL; c++) begin
            checks++;
            if (sb[c].size() != 0) begin
                errors++;
                $display("FAIL sb_left_col%0d: got %0d beats never delivered, required 0", c, sb[c].size());
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
